median_filter_ctrl: RTL and testbench

Stream controller that sequences the free-running `median_filter` datapath (N taps, R_WIDTH bits, no enable) for framed input. It accepts samples over a valid/ready interface and pads each frame edge by replicating the first and last sample H = (N-1)/2 times. It drives the filter input, aligns the filter output, and emits exactly one qualified median per input sample with frame-last marking. It sits between the sample source and the downstream consumer, wrapping one `median_filter` instance.

---
 rtl/median_filter_ctrl.sv | 147 ++++++++++++++
 tb/tb_median_filter_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/median_filter_ctrl.sv
// Framing controller for a free-running median filter.
// Launches one sample per cycle while a frame is open, replicates the first
// and last samples H times, and tags each launch so that only the medians of
// full, in-frame windows reach the output.
module median_filter_ctrl #(
    parameter int R_WIDTH  = 8,
    parameter int N        = 5,
    parameter int FILT_LAT = 2
) (
    input  logic               clk,
    input  logic               srst,
    input  logic [R_WIDTH-1:0] in_data,
    input  logic               in_valid,
    input  logic               in_sof,
    input  logic               in_eof,
    output logic               in_ready,
    output logic [R_WIDTH-1:0] filt_x,
    input  logic [R_WIDTH-1:0] filt_y,
    output logic [R_WIDTH-1:0] out_data,
    output logic               out_valid,
    output logic               out_last,
    output logic               err
);

    localparam int H  = (N - 1) / 2;
    // Wide enough for both the pad counter (0..H-1) and the launch index (0..2H).
    localparam int KW = $clog2(N);
    localparam logic [KW-1:0] K_MAX  = KW'(2 * H);
    localparam logic [KW-1:0] H_LAST = KW'((H > 0) ? H - 1 : 0);

    typedef enum logic [1:0] {IDLE, PRE, RUN, POST} state_t;

    state_t             state;
    logic [KW-1:0]      pad_cnt;
    logic [KW-1:0]      k;
    logic               eof_seen;
    // Tag shift register: [0] is loaded with the launch, [FILT_LAT] lines up with filt_y.
    logic [FILT_LAT:0]  vld_pipe;
    logic [FILT_LAT:0]  last_pipe;

    logic               launch;
    logic               restart;
    logic               last_launch;
    logic [R_WIDTH-1:0] next_x;
    logic [KW-1:0]      k_cur;
    logic               tag_vld;

    assign in_ready  = !srst && (state == IDLE || state == RUN);
    assign out_data  = filt_y;
    assign out_valid = vld_pipe[FILT_LAT];
    assign out_last  = last_pipe[FILT_LAT];

    // Decode what (if anything) is launched this cycle and how it is tagged.
    always_comb begin
        launch      = 1'b0;
        restart     = 1'b0;
        last_launch = 1'b0;
        next_x      = filt_x;
        case (state)
            IDLE: begin
                if (in_valid && in_sof) begin
                    launch      = 1'b1;
                    restart     = 1'b1;
                    next_x      = in_data;
                    last_launch = (H == 0) && in_eof;
                end
            end
            PRE: launch = 1'b1;
            RUN: begin
                // A missing beat relaunches the held sample as a frame sample.
                launch = 1'b1;
                if (in_valid) begin
                    next_x      = in_data;
                    last_launch = (H == 0) && in_eof;
                end
            end
            POST: begin
                launch      = 1'b1;
                last_launch = (pad_cnt == H_LAST);
            end
            default: launch = 1'b0;
        endcase
        k_cur   = restart ? '0 : k;
        tag_vld = launch && (k_cur >= K_MAX);
    end

    // Frame sequencer, launch register, tag pipeline and sticky error.
    always_ff @(posedge clk) begin
        if (srst) begin
            state     <= IDLE;
            filt_x    <= '0;
            pad_cnt   <= '0;
            k         <= '0;
            eof_seen  <= 1'b0;
            vld_pipe  <= '0;
            last_pipe <= '0;
            err       <= 1'b0;
        end else begin
            vld_pipe  <= {vld_pipe[FILT_LAT-1:0], tag_vld};
            last_pipe <= {last_pipe[FILT_LAT-1:0], tag_vld && last_launch};

            if (launch) begin
                filt_x <= next_x;
                k      <= (k_cur >= K_MAX) ? K_MAX : k_cur + KW'(1);
            end

            case (state)
                IDLE: begin
                    if (in_valid && !in_sof) begin
                        err <= 1'b1;
                    end else if (in_valid) begin
                        eof_seen <= in_eof;
                        pad_cnt  <= '0;
                        if (H > 0)       state <= PRE;
                        else if (in_eof) state <= IDLE;
                        else             state <= RUN;
                    end
                end
                PRE: begin
                    if (pad_cnt == H_LAST) begin
                        pad_cnt <= '0;
                        state   <= eof_seen ? POST : RUN;
                    end else begin
                        pad_cnt <= pad_cnt + KW'(1);
                    end
                end
                RUN: begin
                    if (!in_valid || in_sof) err <= 1'b1;
                    if (in_valid && in_eof) begin
                        pad_cnt <= '0;
                        state   <= (H > 0) ? POST : IDLE;
                    end
                end
                POST: begin
                    if (pad_cnt == H_LAST) begin
                        pad_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        pad_cnt <= pad_cnt + KW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_median_filter_ctrl.sv
// Directed bench for median_filter_ctrl with a behavioural 5-tap median
// filter (latency 2) closing the loop between filt_x and filt_y.
module tb_median_filter_ctrl;

    logic       clk = 1'b0;
    logic       srst;
    logic [7:0] in_data;
    logic       in_valid, in_sof, in_eof;
    logic       in_ready;
    logic [7:0] filt_x, filt_y, out_data;
    logic       out_valid, out_last, err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int acc    = 0;

    logic [7:0] win [5];
    logic [7:0] med_r;
    logic [7:0] xhist [0:4095];
    logic [7:0] q_d [$];
    logic       q_l [$];
    int         q_c [$];

    median_filter_ctrl #(.R_WIDTH(8), .N(5), .FILT_LAT(2)) dut (
        .clk(clk), .srst(srst),
        .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof),
        .in_ready(in_ready),
        .filt_x(filt_x), .filt_y(filt_y),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] med5(input logic [7:0] a [5]);
        logic [7:0] s [5];
        logic [7:0] t;
        for (int i = 0; i < 5; i++) s[i] = a[i];
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4 - i; j++)
                if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
        return s[2];
    endfunction

    // Filter model: window shifts every edge, median registered once more.
    initial begin
        for (int i = 0; i < 5; i++) win[i] = 8'd0;
        med_r = 8'd0;
    end
    always @(posedge clk) begin
        for (int i = 4; i > 0; i--) win[i] <= win[i-1];
        win[0] <= filt_x;
        med_r  <= med5(win);
        cyc    <= cyc + 1;
    end
    assign filt_y = med_r;

    // Output capture and launch history, sampled mid-cycle.
    always @(negedge clk) begin
        if (cyc < 4096) xhist[cyc] = filt_x;
        if (out_valid) begin
            q_d.push_back(out_data);
            q_l.push_back(out_last);
            q_c.push_back(cyc);
        end
    end

    task automatic clear_q;
        q_d.delete(); q_l.delete(); q_c.delete();
    endtask

    task automatic send(input logic [7:0] d, input logic s, input logic e);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_sof = s; in_eof = e;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready stayed 0, wanted 1");
        end
        @(posedge clk);
        #1;
        acc = cyc;
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
    endtask

    task automatic wait_out(input int n, input int budget);
        int w = 0;
        while (q_d.size() < n && w < budget) begin @(negedge clk); w++; end
        repeat (8) @(negedge clk);
    endtask

    task automatic pulse_reset;
        @(negedge clk); srst = 1'b1;
        @(negedge clk); srst = 1'b0;
    endtask

    task automatic test_reset;
        srst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_data = 8'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, out_last, err, in_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000", {out_valid, out_last, err, in_ready});
        end
        checks++;
        if (filt_x !== 8'd0) begin errors++; $display("FAIL reset_filt_x: got %0d want 0", filt_x); end
        srst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic;
        logic [7:0] xs [9];
        logic [7:0] ys [5];
        int t0;
        xs = '{255, 255, 255, 200, 10, 166, 131, 131, 131};
        ys = '{255, 200, 166, 131, 131};
        clear_q();
        send(8'd255, 1'b1, 1'b0); t0 = acc;
        send(8'd200, 1'b0, 1'b0);
        send(8'd10,  1'b0, 1'b0);
        send(8'd166, 1'b0, 1'b0);
        send(8'd131, 1'b0, 1'b1);
        wait_out(5, 40);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (xhist[t0+i] !== xs[i]) begin
                errors++;
                $display("FAIL basic_launch[%0d]: got %0d want %0d", i, xhist[t0+i], xs[i]);
            end
        end
        checks++;
        if (q_d.size() !== 5) begin
            errors++; $display("FAIL basic_count: got %0d want 5", q_d.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (q_d[i] !== ys[i] || q_l[i] !== (i == 4) || q_c[i] !== t0 + 6 + i) begin
                    errors++;
                    $display("FAIL basic_out[%0d]: got d=%0d l=%b c=%0d want d=%0d l=%b c=%0d",
                             i, q_d[i], q_l[i], q_c[i], ys[i], (i == 4), t0 + 6 + i);
                end
            end
        end
    endtask

    task automatic test_single;
        int lo = 0;
        int t0;
        clear_q();
        send(8'd77, 1'b1, 1'b1); t0 = acc;
        @(negedge clk);
        while (!in_ready && lo < 20) begin lo++; @(negedge clk); end
        checks++;
        if (lo !== 4) begin errors++; $display("FAIL single_ready_low: got %0d want 4", lo); end
        wait_out(1, 20);
        checks++;
        if (q_d.size() !== 1) begin
            errors++; $display("FAIL single_count: got %0d want 1", q_d.size());
        end else begin
            checks++;
            if (q_d[0] !== 8'd77 || q_l[0] !== 1'b1 || q_c[0] !== t0 + 6) begin
                errors++;
                $display("FAIL single_out: got d=%0d l=%b c=%0d want d=77 l=1 c=%0d",
                         q_d[0], q_l[0], q_c[0], t0 + 6);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] ys [7];
        logic       ls [7];
        ys = '{0, 0, 0, 0, 0, 9, 9};
        ls = '{0, 0, 0, 0, 1, 0, 1};
        clear_q();
        send(8'd0,   1'b1, 1'b0);
        send(8'd0,   1'b0, 1'b0);
        send(8'd255, 1'b0, 1'b0);
        send(8'd0,   1'b0, 1'b0);
        send(8'd0,   1'b0, 1'b1);
        send(8'd9,   1'b1, 1'b0);
        send(8'd9,   1'b0, 1'b1);
        wait_out(7, 60);
        checks++;
        if (q_d.size() !== 7) begin
            errors++; $display("FAIL b2b_count: got %0d want 7", q_d.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (q_d[i] !== ys[i] || q_l[i] !== ls[i]) begin
                    errors++;
                    $display("FAIL b2b_out[%0d]: got d=%0d l=%b want d=%0d l=%b",
                             i, q_d[i], q_l[i], ys[i], ls[i]);
                end
            end
        end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b want 0", err); end
    endtask

    task automatic test_abort;
        logic [7:0] ys [3];
        ys = '{1, 2, 3};
        clear_q();
        send(8'd99, 1'b1, 1'b0);
        @(negedge clk); srst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b want 0", in_ready); end
        @(negedge clk); srst = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (q_d.size() !== 0) begin errors++; $display("FAIL abort_stale: got %0d outputs want 0", q_d.size()); end
        send(8'd1, 1'b1, 1'b0);
        send(8'd2, 1'b0, 1'b0);
        send(8'd3, 1'b0, 1'b1);
        wait_out(3, 30);
        checks++;
        if (q_d.size() !== 3) begin
            errors++; $display("FAIL abort_count: got %0d want 3", q_d.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (q_d[i] !== ys[i] || q_l[i] !== (i == 2)) begin
                    errors++;
                    $display("FAIL abort_out[%0d]: got d=%0d l=%b want d=%0d l=%b",
                             i, q_d[i], q_l[i], ys[i], (i == 2));
                end
            end
        end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL abort_err: got %b want 0", err); end
    endtask

    task automatic test_valid_gap;
        logic [7:0] ys [6];
        ys = '{10, 20, 30, 40, 40, 50};
        clear_q();
        send(8'd10, 1'b1, 1'b0);
        send(8'd20, 1'b0, 1'b0);
        send(8'd30, 1'b0, 1'b0);
        send(8'd40, 1'b0, 1'b0);
        @(posedge clk);
        send(8'd50, 1'b0, 1'b1);
        wait_out(6, 40);
        checks++;
        if (q_d.size() !== 6) begin
            errors++; $display("FAIL gap_count: got %0d want 6", q_d.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (q_d[i] !== ys[i] || q_l[i] !== (i == 5)) begin
                    errors++;
                    $display("FAIL gap_out[%0d]: got d=%0d l=%b want d=%0d l=%b",
                             i, q_d[i], q_l[i], ys[i], (i == 5));
                end
            end
        end
        repeat (5) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL gap_err_sticky: got %b want 1", err); end
    endtask

    task automatic test_no_sof;
        clear_q();
        pulse_reset();
        #1;
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL nosof_err_clear: got %b want 0", err); end
        send(8'd5, 1'b0, 1'b0);
        send(8'd6, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL nosof_err: got %b want 1", err); end
        checks++;
        if (q_d.size() !== 0) begin errors++; $display("FAIL nosof_valid: got %0d outputs want 0", q_d.size()); end
        checks++;
        if (filt_x !== 8'd0) begin errors++; $display("FAIL nosof_launch: got filt_x=%0d want 0", filt_x); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_back_to_back();
        test_abort();
        test_valid_gap();
        test_no_sof();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
